// File: rtl/vec_unit_ctrl_if.sv
// vec_unit_ctrl_if: instruction handshake plus register-file / vector-unit control bus
//   master: instruction source (drives instr_*, observes all controller outputs)
//   slave : the controller (accepts instr_*, drives ready, rf_*, unit_*, status)
interface vec_unit_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2:0]            instr_op;
  logic [REG_ADDR_W-1:0] instr_dst;
  logic [REG_ADDR_W-1:0] instr_src1;
  logic [REG_ADDR_W-1:0] instr_src2;
  logic [31:0]           instr_imm;
  logic                  rf_rd_en;
  logic [REG_ADDR_W-1:0] rf_rd_addr1;
  logic [REG_ADDR_W-1:0] rf_rd_addr2;
  logic [2:0]            unit_op;
  logic [31:0]           unit_k;
  logic                  rf_wr_en;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      retired_count;
  modport master (
    output instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm,
    input  instr_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2, unit_op, unit_k,
           rf_wr_en, rf_wr_addr, busy, done, retired_count
  );
  modport slave (
    input  instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm,
    output instr_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2, unit_op, unit_k,
           rf_wr_en, rf_wr_addr, busy, done, retired_count
  );
endinterface

// File: rtl/vec_unit_ctrl.sv
// vec_unit_ctrl: queued vector-unit sequencer (IDLE -> READ -> EXEC, 1 instr / 2 cycles)
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears FSM, queue and retired counter
//   bus     : slave side of vec_unit_ctrl_if (instruction in, rf/unit control out)
module vec_unit_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic            clock,
  input logic            reset_n,
  vec_unit_ctrl_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, EXEC} state_t;
  typedef struct packed {
    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] dst;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [31:0]           imm;
  } instr_t;
  instr_t           mem_q [FIFO_DEPTH];
  instr_t           cur_q;
  logic [PW-1:0]    wp_q, rp_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             init_q;
  logic [CNT_W-1:0] ret_q;
  state_t           st_q, st_d;
  logic             full, empty, ready, push, pop;
  assign full  = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  // init_q holds ready low for the first cycle after reset release
  assign ready = init_q & ~full;
  assign push  = bus.instr_valid & ready;
  always_comb begin
    pop   = !empty && (st_q != READ);
    st_d  = (st_q == READ) ? EXEC : pop ? READ : IDLE;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clock)
    if (push) mem_q[wp_q] <= '{bus.instr_op, bus.instr_dst, bus.instr_src1, bus.instr_src2, bus.instr_imm};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st_q   <= IDLE;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      init_q <= 1'b0;
      cur_q  <= '0;
      ret_q  <= '0;
    end else begin
      st_q   <= st_d;
      init_q <= 1'b1;
      cnt_q  <= cnt_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q  <= rp_q + 1'b1;
        cur_q <= mem_q[rp_q];
      end
      if (st_q == EXEC) ret_q <= ret_q + 1'b1;
    end
  assign bus.instr_ready   = ready;
  assign bus.rf_rd_en      = st_q == READ;
  assign bus.rf_rd_addr1   = (st_q == READ) ? cur_q.src1 : '0;
  assign bus.rf_rd_addr2   = (st_q == READ) ? cur_q.src2 : '0;
  assign bus.rf_wr_en      = st_q == EXEC;
  assign bus.rf_wr_addr    = (st_q == EXEC) ? cur_q.dst : '0;
  assign bus.done          = st_q == EXEC;
  assign bus.unit_op       = cur_q.op;
  assign bus.unit_k        = cur_q.imm;
  assign bus.busy          = !empty || (st_q != IDLE);
  assign bus.retired_count = ret_q;
endmodule

// File: tb/tb_vec_unit_ctrl.sv
// tb_vec_unit_ctrl: directed scoreboard bench for vec_unit_ctrl
module tb_vec_unit_ctrl;
  typedef struct {
    logic [2:0]  op;
    logic [3:0]  dst;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [31:0] imm;
  } ent_t;
  logic clock = 1'b0;
  logic reset_n;
  vec_unit_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) bus ();
  vec_unit_ctrl #(.REG_ADDR_W(4), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  always #5 clock = ~clock;
  ent_t        exp_q [$];
  int          total = 0, bad = 0;
  int          n_acc = 0, n_rd = 0, n_wr = 0, cyc = 0, last_wr = -1;
  logic        mon_en = 1'b0, burst = 1'b0, saw_full = 1'b0;
  logic [15:0] ret_base = 16'h0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [31:0] imm);
    logic r, acc;
    acc = 1'b0;
    bus.instr_op = op; bus.instr_dst = dst; bus.instr_src1 = s1;
    bus.instr_src2 = s2; bus.instr_imm = imm; bus.instr_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      r = bus.instr_ready;
      if (!r) saw_full = 1'b1;
      @(posedge clock);
      #1;
      if (r) begin
        acc = 1'b1;
        n_acc++;
        exp_q.push_back('{op, dst, s1, s2, imm});
      end
    end
    bus.instr_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask
  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk(tag, exp_q.size() != 0 || bus.busy, 0);
  endtask
  // scoreboard: oldest unretired entry is the one being read or written
  always @(negedge clock) begin
    ent_t e;
    cyc++;
    if (!reset_n) begin
      n_rd = 0;
      n_wr = 0;
    end else if (mon_en) begin
      chk("busy", bus.busy, exp_q.size() != 0);
      chk("retired", bus.retired_count, 16'(ret_base + 16'(n_wr)));
      if (bus.rf_rd_en) begin
        n_rd++;
        chk("rw_overlap", bus.rf_wr_en, 0);
        if (exp_q.size() == 0) chk("rd_spurious", bus.rf_rd_en, 0);
        else begin
          e = exp_q[0];
          chk("rd_addr1", bus.rf_rd_addr1, e.s1);
          chk("rd_addr2", bus.rf_rd_addr2, e.s2);
          chk("rd_op", bus.unit_op, e.op);
          chk("rd_k", bus.unit_k, e.imm);
        end
      end
      if (bus.rf_wr_en) begin
        if (exp_q.size() == 0) chk("wr_spurious", bus.rf_wr_en, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.rf_wr_addr, e.dst);
          chk("wr_op", bus.unit_op, e.op);
          chk("wr_k", bus.unit_k, e.imm);
          chk("done_exec", bus.done, 1);
        end
        n_wr++;
        if (burst && last_wr >= 0) chk("wr_gap", cyc - last_wr, 2);
        last_wr = burst ? cyc : -1;
      end else chk("done_idle", bus.done, 0);
      chk("occupancy", dut.cnt_q, n_acc - n_rd);
      chk("ready", bus.instr_ready, (n_acc - n_rd) != 4);
    end
    if (!burst) last_wr = -1;
  end
  initial begin
    int base;
    logic hit;
    reset_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_dst = '0;
    bus.instr_src1 = '0; bus.instr_src2 = '0; bus.instr_imm = '0;
    #2;
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd", bus.rf_rd_en, 0);
    chk("rst_wr", bus.rf_wr_en, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ret", bus.retired_count, 0);
    chk("rst_k", bus.unit_k, 0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    #1 chk("ready_release", bus.instr_ready, 0);
    @(posedge clock);
    #1 chk("ready_after", bus.instr_ready, 1);
    mon_en = 1'b1;
    // single ADD latency
    push(3'd0, 4'd3, 4'd1, 4'd2, 32'h0);
    chk("lat_t_rd", bus.rf_rd_en, 0);
    @(posedge clock); #1;
    chk("lat_rd_en", bus.rf_rd_en, 1);
    chk("lat_addr1", bus.rf_rd_addr1, 1);
    chk("lat_addr2", bus.rf_rd_addr2, 2);
    @(posedge clock); #1;
    chk("lat_wr_en", bus.rf_wr_en, 1);
    chk("lat_wr_addr", bus.rf_wr_addr, 3);
    chk("lat_op", bus.unit_op, 0);
    chk("lat_done", bus.done, 1);
    @(posedge clock); #1;
    chk("lat_done_off", bus.done, 0);
    chk("lat_ret", bus.retired_count, 1);
    // SCALE operand held from READ through EXEC
    push(3'd3, 4'd5, 4'd6, 4'd7, 32'h40000000);
    @(posedge clock); #1;
    chk("scale_rd_k", bus.unit_k, 32'h40000000);
    chk("scale_rd_op", bus.unit_op, 3);
    chk("scale_rd_a2", bus.rf_rd_addr2, 7);
    @(posedge clock); #1;
    chk("scale_wr_k", bus.unit_k, 32'h40000000);
    chk("scale_wr_op", bus.unit_op, 3);
    drain("scale_drain");
    // back-to-back burst: queue fills, pointers wrap, order kept
    saw_full = 1'b0;
    burst = 1'b1;
    for (int i = 0; i < 12; i++)
      push(3'(i), 4'(i + 4), 4'(i + 1), 4'(i + 2), $urandom);
    drain("burst_drain");
    burst = 1'b0;
    chk("burst_full", saw_full, 1);
    chk("burst_ret", bus.retired_count, 14);
    // counter wrap
    @(posedge clock); #3;
    force dut.ret_q = 16'hFFFF;
    #1 release dut.ret_q;
    ret_base = 16'hFFFF - 16'(n_wr);
    chk("wrap_forced", bus.retired_count, 16'hFFFF);
    push(3'd1, 4'd9, 4'd8, 4'd7, 32'h3f800000);
    drain("wrap_drain");
    chk("wrap_zero", bus.retired_count, 0);
    // reset during READ of the 2nd of 3 queued instructions
    base = n_rd;
    push(3'd5, 4'd1, 4'd2, 4'd3, 32'h1);
    push(3'd6, 4'd2, 4'd3, 4'd4, 32'h2);
    push(3'd7, 4'd3, 4'd4, 4'd5, 32'h3);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.rf_rd_en && n_rd == base + 1) hit = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
    chk("abort_reached", hit, 1);
    mon_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("abort_wr", bus.rf_wr_en, 0);
    chk("abort_rd", bus.rf_rd_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.instr_ready, 0);
    chk("abort_ret", bus.retired_count, 0);
    exp_q.delete();
    n_acc = 0;
    ret_base = 16'h0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("post_ret", bus.retired_count, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_wr", bus.rf_wr_en, 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
